// File: rtl/fp16_align_pipe.sv
// Two-stage multi-lane FP mantissa aligner: finds the maximum effective exponent
// and right-shifts every lane's mantissa to it, keeping guard bits and a sticky bit.
module fp16_align_pipe #(
  parameter int LANES = 4,
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int GUARD = 3
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [LANES*(1+EXP_W+MAN_W)-1:0]     in_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [LANES*(MAN_W+1+GUARD)-1:0]     out_mant,
  output logic [LANES-1:0]                     out_sign,
  output logic [LANES-1:0]                     out_sticky,
  output logic [EXP_W-1:0]                     out_exp,
  output logic                                 out_special
);

  localparam int LW = 1 + EXP_W + MAN_W;
  localparam int AW = MAN_W + 1 + GUARD;
  localparam logic [EXP_W-1:0] EXP_ZERO = {EXP_W{1'b0}};
  localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);
  localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};

  // Saturating right shift; returns {sticky, mantissa}. Shifts of AW or more flush everything to sticky.
  function automatic logic [AW:0] align_lane(input logic [AW-1:0] ext, input logic [EXP_W-1:0] sh);
    logic [AW-1:0] mask;
    logic [AW:0]   res;
    mask = {AW{1'b0}};
    if (int'(sh) >= AW) begin
      res = {|ext, {AW{1'b0}}};
    end else begin
      mask = ~({AW{1'b1}} << sh);
      res  = {|(ext & mask), ext >> sh};
    end
    return res;
  endfunction

  logic                              v1_r, v2_r;
  logic                              s2_ready_s, load1_s, load2_s;

  logic [LANES-1:0][EXP_W-1:0]       exp_raw_s, eff_s;
  logic [LANES-1:0][AW-1:0]          ext_s;
  logic [LANES-1:0]                  sign_s;
  logic [EXP_W-1:0]                  max_eff_s;
  logic                              special_s;

  logic [LANES-1:0][EXP_W-1:0]       eff_r;
  logic [LANES-1:0][AW-1:0]          ext_r;
  logic [LANES-1:0]                  sign1_r;
  logic [EXP_W-1:0]                  max_eff_r;
  logic                              special1_r;

  logic [LANES-1:0][EXP_W-1:0]       sh_s;
  logic [LANES-1:0][AW-1:0]          mant_s;
  logic [LANES-1:0]                  sticky_s;

  logic [LANES-1:0][AW-1:0]          mant_r;
  logic [LANES-1:0]                  sticky_r, sign2_r;
  logic [EXP_W-1:0]                  exp2_r;
  logic                              special2_r;

  assign s2_ready_s = !v2_r || out_ready;
  assign in_ready   = !v1_r || s2_ready_s;
  assign load1_s    = in_valid && in_ready;
  assign load2_s    = v1_r && s2_ready_s;

  // Lane decode and maximum effective exponent reduction for the incoming vector.
  always_comb begin
    exp_raw_s = '0;
    eff_s     = '0;
    ext_s     = '0;
    sign_s    = '0;
    max_eff_s = EXP_ZERO;
    special_s = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      exp_raw_s[i] = in_data[i*LW+MAN_W +: EXP_W];
      eff_s[i]     = (exp_raw_s[i] == EXP_ZERO) ? EXP_ONE : exp_raw_s[i];
      ext_s[i]     = {(exp_raw_s[i] != EXP_ZERO), in_data[i*LW +: MAN_W], {GUARD{1'b0}}};
      sign_s[i]    = in_data[i*LW+LW-1];
      special_s    = special_s | (exp_raw_s[i] == EXP_ONES);
      if (eff_s[i] > max_eff_s) begin
        max_eff_s = eff_s[i];
      end else begin
        max_eff_s = max_eff_s;
      end
    end
  end

  // Stage 1 registers: valid bit plus decoded lanes and the shared maximum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r       <= 1'b0;
      eff_r      <= '0;
      ext_r      <= '0;
      sign1_r    <= '0;
      max_eff_r  <= EXP_ZERO;
      special1_r <= 1'b0;
    end else begin
      v1_r <= load1_s || (v1_r && !s2_ready_s);
      if (load1_s) begin
        eff_r      <= eff_s;
        ext_r      <= ext_s;
        sign1_r    <= sign_s;
        max_eff_r  <= max_eff_s;
        special1_r <= special_s;
      end
    end
  end

  // Per-lane shift amount and saturating alignment of the stage 1 contents.
  always_comb begin
    sh_s     = '0;
    mant_s   = '0;
    sticky_s = '0;
    for (int i = 0; i < LANES; i++) begin
      sh_s[i] = max_eff_r - eff_r[i];
      {sticky_s[i], mant_s[i]} = align_lane(ext_r[i], sh_s[i]);
    end
  end

  // Stage 2 registers drive the outputs directly; held while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_r       <= 1'b0;
      mant_r     <= '0;
      sticky_r   <= '0;
      sign2_r    <= '0;
      exp2_r     <= EXP_ZERO;
      special2_r <= 1'b0;
    end else begin
      v2_r <= load2_s || (v2_r && !out_ready);
      if (load2_s) begin
        mant_r     <= mant_s;
        sticky_r   <= sticky_s;
        sign2_r    <= sign1_r;
        exp2_r     <= max_eff_r;
        special2_r <= special1_r;
      end
    end
  end

  assign out_valid   = v2_r;
  assign out_mant    = mant_r;
  assign out_sticky  = sticky_r;
  assign out_sign    = sign2_r;
  assign out_exp     = exp2_r;
  assign out_special = special2_r;

endmodule
